// File: rtl/id_hazard_scoreboard.sv
// Decode-stage register scoreboard: per-register latency counters drive stall/issue for RAW and WAW hazards.
// Optional macro IDSB_FORWARD_EN: when defined, results count as usable at forwarding time rather than writeback.
module id_hazard_scoreboard #(
    parameter int ALU_LAT  = 1,
    parameter int LOAD_LAT = 2,
    parameter int MUL_LAT  = 4,
    parameter int WB_EXTRA = 2,
    parameter int CNT_W    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid_i,
    input  logic        reg1_read_i,
    input  logic [4:0]  reg1_addr_i,
    input  logic        reg2_read_i,
    input  logic [4:0]  reg2_addr_i,
    input  logic        wreg_write_i,
    input  logic [4:0]  wreg_addr_i,
    input  logic [1:0]  lat_class_i,
    input  logic        ex_stall_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        issue_o,
    output logic [31:0] pending_o
);
    localparam int NREG = 32;

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic [CNT_W-1:0] load_val;
    logic             raw;
    logic             waw;
    logic             issue_int;
    logic             load_en;

    function automatic logic hz(input logic [CNT_W-1:0] k);
`ifdef IDSB_FORWARD_EN
        return k > CNT_W'(1);
`else
        return k != '0;
`endif
    endfunction

    always_comb begin
        case (lat_class_i)
            2'b00:   load_val = CNT_W'(ALU_LAT);
            2'b01:   load_val = CNT_W'(LOAD_LAT);
            default: load_val = CNT_W'(MUL_LAT);
        endcase
`ifndef IDSB_FORWARD_EN
        load_val = load_val + CNT_W'(WB_EXTRA);
`endif
    end

    // Register 0 never holds a nonzero count, so it can never raise a hazard.
    assign raw = (reg1_read_i & hz(cnt_q[reg1_addr_i]))
               | (reg2_read_i & hz(cnt_q[reg2_addr_i]));
    assign waw = wreg_write_i & (wreg_addr_i != 5'd0) & (cnt_q[wreg_addr_i] > load_val);

    assign issue_int = id_valid_i & ~raw & ~waw & ~ex_stall_i & ~flush_i;
    assign load_en   = issue_int & wreg_write_i & (wreg_addr_i != 5'd0);

    assign stall_o = rst & id_valid_i & (raw | waw) & ~flush_i;
    assign issue_o = rst & issue_int;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
            assign pending_o[gi] = rst & (cnt_q[gi] != '0);
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
            if (i == 0 || flush_i) begin
                cnt_d[i] = '0;
            end else if (!ex_stall_i) begin
                if (load_en && wreg_addr_i == 5'(i)) begin
                    cnt_d[i] = load_val;
                end else if (cnt_q[i] != '0) begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (!rst) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Scoreboard bench: a timestamp-based model predicts stall/issue/pending per cycle; a monitor pops and compares.
// Honours IDSB_FORWARD_EN the same way as the design.
module tb_id_hazard_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid_i;
    logic        reg1_read_i;
    logic [4:0]  reg1_addr_i;
    logic        reg2_read_i;
    logic [4:0]  reg2_addr_i;
    logic        wreg_write_i;
    logic [4:0]  wreg_addr_i;
    logic [1:0]  lat_class_i;
    logic        ex_stall_i;
    logic        flush_i;
    logic        stall_o;
    logic        issue_o;
    logic [31:0] pending_o;

    always #5 clk = ~clk;

    id_hazard_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid_i   (id_valid_i),
        .reg1_read_i  (reg1_read_i),
        .reg1_addr_i  (reg1_addr_i),
        .reg2_read_i  (reg2_read_i),
        .reg2_addr_i  (reg2_addr_i),
        .wreg_write_i (wreg_write_i),
        .wreg_addr_i  (wreg_addr_i),
        .lat_class_i  (lat_class_i),
        .ex_stall_i   (ex_stall_i),
        .flush_i      (flush_i),
        .stall_o      (stall_o),
        .issue_o      (issue_o),
        .pending_o    (pending_o)
    );

    typedef struct {
        int          id;
        logic        stall;
        logic        issue;
        logic [31:0] pend;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   txn   = 0;

    // Model: t advances only on cycles where the pipeline moves; a register's
    // result becomes usable at absolute time avail[r].
    int t = 0;
    int avail[32];

    function automatic int rem(input int r);
        if (r == 0) return 0;
        return (avail[r] > t) ? avail[r] - t : 0;
    endfunction

    function automatic bit hzm(input int k);
`ifdef IDSB_FORWARD_EN
        return k > 1;
`else
        return k != 0;
`endif
    endfunction

    function automatic int lval(input logic [1:0] c);
        int v;
        case (c)
            2'b00:   v = 1;
            2'b01:   v = 2;
            default: v = 4;
        endcase
`ifndef IDSB_FORWARD_EN
        v = v + 2;
`endif
        return v;
    endfunction

    task automatic drive(input logic rs, input logic v,
                         input logic r1, input logic [4:0] a1,
                         input logic r2, input logic [4:0] a2,
                         input logic wr, input logic [4:0] wa,
                         input logic [1:0] cls, input logic exs,
                         input logic fl, output logic iss);
        exp_t e;
        bit   raw, waw;
        int   l;
        @(negedge clk);
        rst = rs; id_valid_i = v;
        reg1_read_i = r1; reg1_addr_i = a1;
        reg2_read_i = r2; reg2_addr_i = a2;
        wreg_write_i = wr; wreg_addr_i = wa;
        lat_class_i = cls; ex_stall_i = exs; flush_i = fl;

        l   = lval(cls);
        raw = (r1 && hzm(rem(int'(a1)))) || (r2 && hzm(rem(int'(a2))));
        waw = wr && (wa != 5'd0) && (rem(int'(wa)) > l);
        e.id    = txn;
        e.stall = rs && v && (raw || waw) && !fl;
        e.issue = rs && v && !raw && !waw && !exs && !fl;
        for (int r = 0; r < 32; r++) e.pend[r] = rs && (rem(r) != 0);
        exp_q.push_back(e);
        txn++;
        iss = e.issue;

        if (!rs || fl) begin
            for (int r = 0; r < 32; r++) avail[r] = t;
        end else if (!exs) begin
            if (e.issue && wr && wa != 5'd0) avail[wa] = t + 1 + l;
            t++;
        end
    endtask

    // Hold one instruction in ID until it issues (as the IF/ID register would).
    task automatic issue_instr(input logic r1, input logic [4:0] a1,
                               input logic r2, input logic [4:0] a2,
                               input logic wr, input logic [4:0] wa,
                               input logic [1:0] cls);
        logic iss;
        iss = 1'b0;
        for (int k = 0; k < 20 && !iss; k++)
            drive(1, 1, r1, a1, r2, a2, wr, wa, cls, 0, 0, iss);
        if (!iss) begin
            n_cmp++; n_bad++;
            $display("FAIL issue_timeout txn %0d: no issue within 20 cycles, required issue", txn);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("txn %0d: stall=%b issue=%b pending=%h", e.id, stall_o, issue_o, pending_o);
                n_cmp++;
                if (stall_o !== e.stall) begin
                    n_bad++;
                    $display("FAIL stall txn %0d: got %b want %b", e.id, stall_o, e.stall);
                end
                n_cmp++;
                if (issue_o !== e.issue) begin
                    n_bad++;
                    $display("FAIL issue txn %0d: got %b want %b", e.id, issue_o, e.issue);
                end
                n_cmp++;
                if (pending_o !== e.pend) begin
                    n_bad++;
                    $display("FAIL pending txn %0d: got %h want %h", e.id, pending_o, e.pend);
                end
            end
        end
    end

    initial begin : driver
        logic iss;
        for (int r = 0; r < 32; r++) avail[r] = 0;
        rst = 1'b0; id_valid_i = 0; reg1_read_i = 0; reg1_addr_i = 0;
        reg2_read_i = 0; reg2_addr_i = 0; wreg_write_i = 0; wreg_addr_i = 0;
        lat_class_i = 0; ex_stall_i = 0; flush_i = 0;

        drive(0, 1, 1, 5'd3, 1, 5'd4, 1, 5'd5, 2'b10, 0, 0, iss);
        drive(0, 1, 1, 5'd3, 1, 5'd4, 1, 5'd5, 2'b10, 0, 0, iss);
        drive(1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 2'b00, 0, 0, iss);

        // ALU producer then consumer
        issue_instr(0, 5'd0, 0, 5'd0, 1, 5'd3, 2'b00);
        issue_instr(1, 5'd3, 0, 5'd0, 0, 5'd0, 2'b00);
        // LOAD then consumer, MUL then consumer on source 2
        issue_instr(0, 5'd0, 0, 5'd0, 1, 5'd5, 2'b01);
        issue_instr(1, 5'd5, 0, 5'd0, 0, 5'd0, 2'b00);
        issue_instr(0, 5'd0, 0, 5'd0, 1, 5'd7, 2'b10);
        issue_instr(0, 5'd0, 1, 5'd7, 0, 5'd0, 2'b00);
        // WAW: long writer followed by short writer to the same register
        issue_instr(0, 5'd0, 0, 5'd0, 1, 5'd8, 2'b11);
        issue_instr(0, 5'd0, 0, 5'd0, 1, 5'd8, 2'b00);
        drive(1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 2'b00, 0, 0, iss);
        // Freeze with a pending load, then flush
        issue_instr(0, 5'd0, 0, 5'd0, 1, 5'd9, 2'b01);
        for (int k = 0; k < 3; k++)
            drive(1, 1, 1, 5'd9, 0, 5'd0, 0, 5'd0, 2'b00, 1, 0, iss);
        drive(1, 1, 1, 5'd9, 0, 5'd0, 0, 5'd0, 2'b00, 0, 1, iss);
        issue_instr(1, 5'd9, 0, 5'd0, 0, 5'd0, 2'b00);
        // Source/dest same register, and $0 never hazards
        issue_instr(0, 5'd0, 0, 5'd0, 1, 5'd6, 2'b10);
        issue_instr(1, 5'd6, 0, 5'd0, 1, 5'd6, 2'b00);
        issue_instr(0, 5'd0, 0, 5'd0, 1, 5'd0, 2'b10);
        drive(1, 1, 1, 5'd0, 1, 5'd0, 1, 5'd0, 2'b10, 0, 0, iss);
        for (int k = 0; k < 6; k++)
            drive(1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 2'b00, 0, 0, iss);

        // Randomized traffic on a small register window to provoke hazards
        for (int k = 0; k < 500; k++) begin
            drive(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 9) != 0),
                  1'($urandom), 5'($urandom_range(0, 7)),
                  1'($urandom), 5'($urandom_range(0, 7)),
                  1'($urandom), 5'($urandom_range(0, 7)),
                  2'($urandom),
                  ($urandom_range(0, 6) == 0),
                  ($urandom_range(0, 24) == 0),
                  iss);
        end

        repeat (3) @(negedge clk);
        #4;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
